// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM states and
// the default debounce / long-press cycle counts for a 100 MHz fpga_clk.
package btn_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms of stable input at 100 MHz before a change is accepted.
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

  // 1 s of continuous accepted hold before the long-press pulse.
  localparam int LONG_CYCLES_DEF = 100_000_000;

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// One push-button channel: two-flop synchroniser, debounce FSM with a
// stability counter, and registered level / press / release pulses.
// Optional feature macro: BTN_LONG_PRESS_EN adds a hold counter and the
// one-shot long-press pulse; without it o_long is tied low.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BTN_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  btn_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_level;
  logic            r_press;
  logic            r_release;

  btn_state_t      w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_level_nxt;
  logic            w_press_nxt;
  logic            w_release_nxt;

  // Bring the asynchronous button into the fpga_clk domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce decision: a change is accepted only after CNT_MAX+1 stable samples.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_level_nxt = 1'b0;
        if (r_sync2) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = {CW{1'b0}};
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      HELD: begin
        w_level_nxt = 1'b1;
        if (!r_sync2) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = HELD;
        end
      end
      RELEASE_WAIT: begin
        if (r_sync2) begin
          // Bounce back to pressed: level never dropped, so no pulse.
          w_state_nxt = HELD;
          w_cnt_nxt   = {CW{1'b0}};
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = {CW{1'b0}};
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CW{1'b0}};
        w_level_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= {CW{1'b0}};
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] r_hold;
  logic          r_long_done;
  logic          r_long;
  logic          w_hold_clr;
  logic          w_in_hold;

  // A fresh accepted press restarts the hold measurement.
  assign w_hold_clr = (r_state == PRESS_WAIT) && (w_state_nxt == HELD);
  // Bounces through RELEASE_WAIT keep counting toward the long press.
  assign w_in_hold  = (r_state == HELD) || (r_state == RELEASE_WAIT);

  // Saturating hold counter with a single long-press pulse per press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold      <= {HW{1'b0}};
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end else if (w_hold_clr) begin
      r_hold      <= {HW{1'b0}};
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end else if (w_in_hold) begin
      if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + HW'(1);
      end else begin
        r_hold <= r_hold;
      end
      r_long      <= (r_hold == HOLD_MAX) && !r_long_done;
      r_long_done <= r_long_done || (r_hold == HOLD_MAX);
    end else begin
      r_hold      <= {HW{1'b0}};
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent debounced channels plus an
// any-press summary for the mode controller.
// Optional feature macro: BTN_LONG_PRESS_EN enables the btn_long pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic             fpga_clk,
  input  logic             rst_ctrl,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             any_press
);

  // Reject parameter sets the channel logic cannot honour.
  if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES <= DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("btn_conditioner: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_LONG_PRESS_EN
      ,
      .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_ch (
      .i_clk     (fpga_clk),
      .i_rst     (rst_ctrl),
      .i_btn_raw (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g])
    );
  end

  // Registered press pulses OR-ed for the mode controller trigger.
  assign any_press = |btn_press;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
// Stimulus pushes the expected output event (cycle, pulses, level) into a
// queue; the monitor pops and compares whenever any pulse output is high.
module tb_btn_conditioner;

  localparam int NB  = 5;
  localparam int LAT = 10;  // 2 sync edges + 8 debounce edges
  localparam int LNG = 32;

  typedef struct {
    int         cyc;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] lng;
    logic [4:0] lvl;
  } ev_t;

  logic          fpga_clk = 1'b0;
  logic          rst_ctrl;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;
  logic          any_press;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [4:0] exp_lvl = 5'h00;

  btn_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(LNG)
  ) dut (
    .fpga_clk(fpga_clk), .rst_ctrl(rst_ctrl), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .any_press(any_press)
  );

  always #5 fpga_clk = ~fpga_clk;

  always @(posedge fpga_clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  task automatic push(int c, logic [4:0] p, logic [4:0] r, logic [4:0] l, logic [4:0] v);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.lvl = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge fpga_clk);
  endtask

  // Monitor: reset-state checks, then event pop/compare or steady-level check.
  always @(negedge fpga_clk) begin
    ev_t e;
    if (rst_ctrl) begin
      chk("rst_level", int'(btn_level), 0);
      chk("rst_pulses", int'(btn_press | btn_release | btn_long), 0);
      chk("rst_any", int'(any_press), 0);
      exp_lvl = 5'h00;
    end else begin
      chk("any_press_or", int'(any_press), int'(|btn_press));
      if ((btn_press | btn_release | btn_long) != 5'h00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", int'({btn_press, btn_release, btn_long}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_press", int'(btn_press), int'(e.press));
          chk("ev_release", int'(btn_release), int'(e.rel));
          chk("ev_long", int'(btn_long), int'(e.lng));
          chk("ev_level", int'(btn_level), int'(e.lvl));
          exp_lvl = e.lvl;
        end
      end else begin
        chk("steady_level", int'(btn_level), int'(exp_lvl));
      end
    end
  end

  initial begin
    int e0;
    rst_ctrl = 1'b1;
    btn_raw  = 5'h1F;
    wait_n(3);

    // Reset with all buttons held: fresh press on every channel.
    @(negedge fpga_clk);
    rst_ctrl = 1'b0;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h1F, 5'h00, 5'h00, 5'h1F);
    wait_n(12);
    btn_raw = 5'h00;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h00, 5'h1F, 5'h00, 5'h00);
    wait_n(14);

    // Clean press / release of bit 2.
    btn_raw = 5'h04;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h04, 5'h00, 5'h00, 5'h04);
    wait_n(12);
    btn_raw = 5'h00;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h00, 5'h04, 5'h00, 5'h00);
    wait_n(14);

    // Bounce on bit 3: 1 for 5, 0 for 2, then steady 1.
    btn_raw = 5'h08;
    wait_n(5);
    btn_raw = 5'h00;
    wait_n(2);
    btn_raw = 5'h08;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h08, 5'h00, 5'h00, 5'h08);
    wait_n(12);
    btn_raw = 5'h00;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h00, 5'h08, 5'h00, 5'h00);
    wait_n(14);

    // Long press on bit 0 held 50 cycles.
    btn_raw = 5'h01;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h01, 5'h00, 5'h00, 5'h01);
`ifdef BTN_LONG_PRESS_EN
    push(e0 + LAT + LNG, 5'h00, 5'h00, 5'h01, 5'h01);
`endif
    wait_n(50);
    btn_raw = 5'h00;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h00, 5'h01, 5'h00, 5'h00);
    wait_n(14);

    // Bit 1: held past the long press, then a 7-cycle low glitch.
    btn_raw = 5'h02;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h02, 5'h00, 5'h00, 5'h02);
`ifdef BTN_LONG_PRESS_EN
    push(e0 + LAT + LNG, 5'h00, 5'h00, 5'h02, 5'h02);
`endif
    wait_n(45);
    btn_raw = 5'h00;
    wait_n(7);
    btn_raw = 5'h02;
    wait_n(40);
    btn_raw = 5'h00;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h00, 5'h02, 5'h00, 5'h00);
    wait_n(14);

    // Reset during bit-4 PRESS_WAIT while bit 2 is already accepted.
    btn_raw = 5'h04;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h04, 5'h00, 5'h00, 5'h04);
    wait_n(12);
    btn_raw = 5'h14;
    wait_n(5);
    #1 rst_ctrl = 1'b1;
    #1;
    chk("async_rst_level", int'(btn_level), 0);
    chk("async_rst_press", int'(btn_press), 0);
    wait_n(3);
    rst_ctrl = 1'b0;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h14, 5'h00, 5'h00, 5'h14);
    wait_n(12);
    btn_raw = 5'h00;
    e0 = cyc + 1;
    push(e0 + LAT, 5'h00, 5'h14, 5'h00, 5'h00);
    wait_n(20);

    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_btn_conditioner
